spike_readout: RTL and testbench

SPIKE_READOUT -- requirements
Module: spike_readout

---
 rtl/snn_pkg.sv | 25 ++
 rtl/readout_argmax.sv | 26 ++
 rtl/spike_readout.sv | 135 +++++++++++++
 tb/tb_spike_readout.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared state encodings and derived-size helpers for the SNN readout slice.
package snn_pkg;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCUM  = 2'd1;
   localparam logic [1:0] S_ARGMAX = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   function automatic int unsigned calc_beats(input int unsigned n_neuron,
                                              input int unsigned io_width);
      return n_neuron / io_width;
   endfunction

   // Index width that stays at least one bit for single-entry ranges
   function automatic int unsigned calc_idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DEF_IO_WIDTH   = 8;
   localparam int unsigned DEF_N_NEURON   = 16;
   localparam int unsigned BEATS          = calc_beats(DEF_N_NEURON, DEF_IO_WIDTH);
   localparam int unsigned CLS_WIDTH      = calc_idx_width(DEF_N_NEURON);
   localparam int unsigned BEAT_IDX_WIDTH = calc_idx_width(BEATS);

endpackage

// File: rtl/readout_argmax.sv
// Sequential argmax: one value per enabled cycle, ties keep the earliest index.
module readout_argmax #(
   parameter int unsigned CLS_W = 4,
   parameter int unsigned VAL_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             first,
   input  logic [CLS_W-1:0] idx,
   input  logic [VAL_W-1:0] value,
   output logic [CLS_W-1:0] best_idx,
   output logic [VAL_W-1:0] best_val
);

   always_ff @(posedge clk) begin
      if (rst) begin
         best_idx <= '0;
         best_val <= '0;
      end else if (en && (first || (value > best_val))) begin
         best_idx <= idx;
         best_val <= value;
      end
   end

endmodule

// File: rtl/spike_readout.sv
// Output-layer spike counter bank with a sequential argmax classifier.
module spike_readout
   import snn_pkg::*;
#(
   parameter int unsigned IO_WIDTH  = 8,
   parameter int unsigned N_NEURON  = 16,
   parameter int unsigned T_WIDTH   = 5,
   parameter int unsigned CNT_WIDTH = 6
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic                                START,
   input  logic [T_WIDTH-1:0]                  NUM_T,
   input  logic                                IN_VALID,
   input  logic [IO_WIDTH-1:0]                 IN_SPIKE,
   output logic                                BUSY,
   output logic                                RES_VALID,
   input  logic                                RES_READY,
   output logic [calc_idx_width(N_NEURON)-1:0] RES_CLASS,
   output logic [CNT_WIDTH-1:0]                RES_COUNT,
   output logic                                SAT
);

   localparam int unsigned N_BEATS = calc_beats(N_NEURON, IO_WIDTH);
   localparam int unsigned CLS_W   = calc_idx_width(N_NEURON);
   localparam int unsigned BIDX_W  = calc_idx_width(N_BEATS);

   logic [1:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q [N_NEURON];
   logic [BIDX_W-1:0]    beat_q;
   logic [T_WIDTH-1:0]   step_q;
   logic [T_WIDTH-1:0]   num_t_q;
   logic [CLS_W-1:0]     scan_q;
   logic                 sat_q, busy_q, res_valid_q;
   logic [N_NEURON-1:0]  hit_c, full_c;
   logic                 start_c, beat_c, beat_wrap_c, last_beat_c, scan_last_c, accept_c;

   assign start_c     = (state_q == S_IDLE) && START;
   assign beat_c      = (state_q == S_ACCUM) && IN_VALID;
   assign beat_wrap_c = (beat_q == BIDX_W'(N_BEATS - 1));
   assign last_beat_c = beat_c && beat_wrap_c && (step_q == num_t_q);
   assign scan_last_c = (state_q == S_ARGMAX) && (scan_q == CLS_W'(N_NEURON - 1));
   assign accept_c    = (state_q == S_DONE) && res_valid_q && RES_READY;

   // Per-neuron increment request for the beat currently on the bus
   for (genvar g = 0; g < N_NEURON; g++) begin : g_hit
      assign hit_c[g]  = beat_c && (beat_q == BIDX_W'(g / IO_WIDTH)) && IN_SPIKE[g % IO_WIDTH];
      assign full_c[g] = (cnt_q[g] == {CNT_WIDTH{1'b1}});
   end

   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_c)     state_d = S_ACCUM;
         S_ACCUM:  if (last_beat_c) state_d = S_ARGMAX;
         S_ARGMAX: if (scan_last_c) state_d = S_DONE;
         S_DONE:   if (accept_c)    state_d = S_IDLE;
         default:                   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         busy_q      <= (state_d == S_ACCUM) || (state_d == S_ARGMAX);
         res_valid_q <= (state_d == S_DONE);
      end
   end

   // Saturating counter bank
   always_ff @(posedge CLK) begin
      if (RST || start_c) begin
         for (int n = 0; n < N_NEURON; n++) cnt_q[n] <= '0;
      end else begin
         for (int n = 0; n < N_NEURON; n++)
            if (hit_c[n] && !full_c[n]) cnt_q[n] <= cnt_q[n] + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || start_c)              sat_q <= 1'b0;
      else if (|(hit_c & full_c))      sat_q <= 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         beat_q  <= '0;
         step_q  <= '0;
         num_t_q <= '0;
      end else if (start_c) begin
         beat_q  <= '0;
         step_q  <= '0;
         num_t_q <= NUM_T;
      end else if (beat_c) begin
         if (beat_wrap_c) begin
            beat_q <= '0;
            step_q <= step_q + T_WIDTH'(1);
         end else begin
            beat_q <= beat_q + BIDX_W'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST)                       scan_q <= '0;
      else if (state_q == S_ARGMAX)  scan_q <= scan_last_c ? '0 : scan_q + CLS_W'(1);
      else                           scan_q <= '0;
   end

   readout_argmax #(
      .CLS_W (CLS_W),
      .VAL_W (CNT_WIDTH)
   ) u_argmax (
      .clk      (CLK),
      .rst      (RST),
      .en       (state_q == S_ARGMAX),
      .first    (scan_q == '0),
      .idx      (scan_q),
      .value    (cnt_q[scan_q]),
      .best_idx (RES_CLASS),
      .best_val (RES_COUNT)
   );

   assign BUSY      = busy_q;
   assign RES_VALID = res_valid_q;
   assign SAT       = sat_q;

endmodule

// File: tb/tb_spike_readout.sv
// Scoreboard bench for spike_readout: default instance plus a CNT_WIDTH=4 twin.
module tb_spike_readout;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       START = 1'b0;
   logic [4:0] NUM_T = '0;
   logic       IN_VALID = 1'b0;
   logic [7:0] IN_SPIKE = '0;
   logic       RES_READY = 1'b0;

   logic       busy, res_valid, sat;
   logic [3:0] res_class;
   logic [5:0] res_count;
   logic       busy_s, res_valid_s, sat_s;
   logic [3:0] res_class_s;
   logic [3:0] res_count_s;

   typedef struct {
      int cls; int cnt; int sat;
      int cls_s; int cnt_s; int sat_s;
   } exp_t;

   exp_t sb[$];
   int   mcnt[16];
   bit   model_on = 1'b0;
   int   mbeat = 0;
   int   n_total = 0;
   int   n_bad = 0;

   always #5 CLK = ~CLK;

   spike_readout dut (
      .CLK(CLK), .RST(RST), .START(START), .NUM_T(NUM_T),
      .IN_VALID(IN_VALID), .IN_SPIKE(IN_SPIKE), .BUSY(busy),
      .RES_VALID(res_valid), .RES_READY(RES_READY),
      .RES_CLASS(res_class), .RES_COUNT(res_count), .SAT(sat)
   );

   spike_readout #(.CNT_WIDTH(4)) dut_s (
      .CLK(CLK), .RST(RST), .START(START), .NUM_T(NUM_T),
      .IN_VALID(IN_VALID), .IN_SPIKE(IN_SPIKE), .BUSY(busy_s),
      .RES_VALID(res_valid_s), .RES_READY(RES_READY),
      .RES_CLASS(res_class_s), .RES_COUNT(res_count_s), .SAT(sat_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference argmax over the model counts for a given counter ceiling
   function automatic void calc(input int cap, output int cls, output int cnt, output int sv);
      int v;
      cls = 0; cnt = 0; sv = 0;
      for (int n = 0; n < 16; n++) begin
         v = (mcnt[n] > cap) ? cap : mcnt[n];
         if (mcnt[n] > cap) sv = 1;
         if (n == 0 || v > cnt) begin
            cls = n;
            cnt = v;
         end
      end
   endfunction

   task automatic start_run(input int num_t);
      START = 1'b1;
      NUM_T = 5'(num_t);
      tick();
      START = 1'b0;
      for (int n = 0; n < 16; n++) mcnt[n] = 0;
      mbeat = 0;
      model_on = 1'b1;
      check("busy_after_start", busy, 1);
      check("sat_clear_on_start", sat, 0);
      check("sat_s_clear_on_start", sat_s, 0);
   endtask

   task automatic drive_beat(input logic [7:0] b, input int gap);
      repeat (gap) tick();
      IN_VALID = 1'b1;
      IN_SPIKE = b;
      tick();
      IN_VALID = 1'b0;
      if (model_on) begin
         for (int i = 0; i < 8; i++) if (b[i]) mcnt[mbeat*8 + i]++;
         mbeat ^= 1;
      end
   endtask

   task automatic push_expect();
      exp_t e;
      calc(63, e.cls, e.cnt, e.sat);
      calc(15, e.cls_s, e.cnt_s, e.sat_s);
      sb.push_back(e);
      model_on = 1'b0;
   endtask

   task automatic run_steps(input int num_t, input logic [7:0] b0, input logic [7:0] b1, input int gap);
      start_run(num_t);
      for (int s = 0; s <= num_t; s++) begin
         drive_beat(b0, gap);
         drive_beat(b1, 0);
      end
      push_expect();
   endtask

   // Called right after the last beat's accepting edge; hold>0 applies backpressure
   task automatic wait_result(input int hold, input int exp_lat);
      exp_t e;
      int   lat = 1;
      while (res_valid !== 1'b1 && lat < 60) begin
         tick();
         lat++;
      end
      if (res_valid !== 1'b1) begin
         check("res_valid_timeout", res_valid, 1);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      if (exp_lat > 0) check("latency", lat, exp_lat);
      if (sb.size() == 0) begin
         check("scoreboard_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      check("res_class", res_class, e.cls);
      check("res_count", res_count, e.cnt);
      check("sat", sat, e.sat);
      check("res_valid_s", res_valid_s, 1);
      check("res_class_s", res_class_s, e.cls_s);
      check("res_count_s", res_count_s, e.cnt_s);
      check("sat_s", sat_s, e.sat_s);
      for (int h = 0; h < hold; h++) begin
         START = (h == 4);
         NUM_T = 5'd2;
         tick();
         START = 1'b0;
         check("hold_valid", res_valid, 1);
         check("hold_class", res_class, e.cls);
         check("hold_count", res_count, e.cnt);
         check("hold_busy", busy, 0);
      end
      RES_READY = 1'b1;
      tick();
      RES_READY = 1'b0;
      check("valid_drop", res_valid, 0);
      check("busy_idle", busy, 0);
      check("idle_class", res_class, e.cls);
      check("idle_count", res_count, e.cnt);
   endtask

   initial begin
      logic [7:0] rb;
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_valid", res_valid, 0);
      check("rst_class", res_class, 0);
      check("rst_count", res_count, 0);
      check("rst_sat", sat, 0);

      // Beats while idle must not leak into the next run
      drive_beat(8'hFF, 0);
      drive_beat(8'hFF, 0);
      check("idle_beats_busy", busy, 0);

      run_steps(0, 8'h01, 8'h00, 0);
      wait_result(0, 17);

      run_steps(3, 8'h20, 8'h10, 0);
      wait_result(0, 17);

      run_steps(31, 8'h00, 8'h02, 0);
      wait_result(0, 17);

      // Randomised run with idle gaps, followed by backpressure with a stray START
      start_run(5);
      for (int s = 0; s < 6; s++) begin
         rb = 8'($urandom);
         drive_beat(rb, $urandom_range(0, 2));
         rb = 8'($urandom);
         drive_beat(rb, $urandom_range(0, 2));
      end
      push_expect();
      wait_result(10, 17);

      // Abort mid-accumulation with neuron 3 at count 7
      start_run(10);
      for (int s = 0; s < 7; s++) begin
         drive_beat(8'h08, 0);
         drive_beat(8'h00, 0);
      end
      model_on = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_valid", res_valid, 0);
      check("abort_count", res_count, 0);
      run_steps(0, 8'h04, 8'h00, 0);
      wait_result(0, 17);

      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
